// File: rtl/creg_arbiter.sv
// Round-robin arbiter sharing the control-register port among NUM_REQ requesters,
// with read-data return routing and an SPI/GPIO guard. Optional macro: CREG_ARB_LOCK_EN.
module creg_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned IO_GUARD = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    IN_req,
  input  logic [NUM_REQ-1:0]    IN_reqWe,
  input  logic [4*NUM_REQ-1:0]  IN_reqWm,
  input  logic [7*NUM_REQ-1:0]  IN_reqAddr,
  input  logic [32*NUM_REQ-1:0] IN_reqData,
`ifdef CREG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    IN_lock,
`endif
  output logic [NUM_REQ-1:0]    OUT_grant,
  output logic [NUM_REQ-1:0]    OUT_rvalid,
  output logic [31:0]           OUT_rdata,
  output logic                  OUT_ce,
  output logic                  OUT_we,
  output logic [3:0]            OUT_wm,
  output logic [6:0]            OUT_addr,
  output logic [31:0]           OUT_data,
  input  logic [31:0]           IN_cregData,
  input  logic                  IN_ioBusy
);

  localparam int unsigned ID_W   = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned CNT_W  = ID_W + 1;
  localparam int unsigned GRD_W  = (IO_GUARD > 0) ? $clog2(IO_GUARD + 1) : 1;
  localparam int unsigned PIPE_W = RD_LAT * ID_W;

  // SPI data and GPIO output registers; accesses must not overlap an ongoing operation
  function automatic logic is_io(input logic [6:0] a);
    return !a[5] && ((a[4:0] == 5'd4) || (a[4:0] == 5'd5));
  endfunction

  logic [3:0]  wm_a   [NUM_REQ];
  logic [6:0]  addr_a [NUM_REQ];
  logic [31:0] data_a [NUM_REQ];
  logic [NUM_REQ-1:0] io_a;
  logic [NUM_REQ-1:0] elig_raw;
  logic [NUM_REQ-1:0] elig;
  logic               blocked;

  logic [CNT_W-1:0] scan;
  logic [CNT_W-1:0] ptr_nxt;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;

  logic [ID_W-1:0]    ptr_q,    ptr_d;
  logic [GRD_W-1:0]   guard_q,  guard_d;
  logic               ce_q,     ce_d;
  logic               we_q,     we_d;
  logic [3:0]         wm_q,     wm_d;
  logic [6:0]         addr_q,   addr_d;
  logic [31:0]        data_q,   data_d;
  logic [RD_LAT-1:0]  pv_q,     pv_d;
  logic [PIPE_W-1:0]  pid_q,    pid_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]        rdata_q,  rdata_d;
`ifdef CREG_ARB_LOCK_EN
  logic               lock_q,    lock_d;
  logic [ID_W-1:0]    lock_id_q, lock_id_d;
`endif

  assign blocked = IN_ioBusy || (guard_q != '0);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign wm_a[g]     = IN_reqWm[4*g +: 4];
    assign addr_a[g]   = IN_reqAddr[7*g +: 7];
    assign data_a[g]   = IN_reqData[32*g +: 32];
    assign io_a[g]     = is_io(IN_reqAddr[7*g +: 7]);
    assign elig_raw[g] = IN_req[g] && !(io_a[g] && blocked);
  end

  // Eligibility mask and round-robin scan starting at the pointer
  always_comb begin
    elig    = elig_raw;
`ifdef CREG_ARB_LOCK_EN
    if (lock_q && IN_req[lock_id_q]) elig = elig_raw & (NUM_REQ'(1) << lock_id_q);
`endif
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = CNT_W'(ptr_q) + CNT_W'(i);
      if (scan >= CNT_W'(NUM_REQ)) scan = scan - CNT_W'(NUM_REQ);
      if (!gnt_vld && elig[scan[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan[ID_W-1:0];
      end
    end
    gnt_vld = gnt_vld && !rst;
  end

  assign OUT_grant = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;

  // Next-state for port registers, pointer, guard and read-return pipe
  always_comb begin
    ptr_d    = ptr_q;
    guard_d  = guard_q;
    ce_d     = 1'b1;
    we_d     = we_q;
    wm_d     = wm_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    ptr_nxt  = CNT_W'(gnt_id) + CNT_W'(1);
    if (ptr_nxt >= CNT_W'(NUM_REQ)) ptr_nxt = '0;

    if (guard_q != '0) guard_d = guard_q - GRD_W'(1);

    if (gnt_vld) begin
      ptr_d  = ptr_nxt[ID_W-1:0];
      ce_d   = 1'b0;
      we_d   = ~IN_reqWe[gnt_id];
      wm_d   = wm_a[gnt_id];
      addr_d = addr_a[gnt_id];
      data_d = data_a[gnt_id];
      if (io_a[gnt_id]) guard_d = GRD_W'(IO_GUARD);
    end

    // Stage 0 holds a read granted this cycle; the last stage fires rvalid next cycle
    pv_d  = (pv_q << 1) | RD_LAT'(gnt_vld && !IN_reqWe[gnt_id]);
    pid_d = (pid_q << ID_W) | PIPE_W'(gnt_id);
    if (pv_q[RD_LAT-1]) begin
      rvalid_d = NUM_REQ'(1) << pid_q[PIPE_W-1 -: ID_W];
      rdata_d  = IN_cregData;
    end
  end

`ifdef CREG_ARB_LOCK_EN
  // Lock follows the granted requester; released on an unlocked grant or a dropped request
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (gnt_vld) begin
      lock_d    = IN_lock[gnt_id];
      lock_id_d = gnt_id;
    end else if (lock_q && !IN_req[lock_id_q]) begin
      lock_d    = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      guard_q   <= '0;
      ce_q      <= 1'b1;
      we_q      <= 1'b1;
      wm_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      pv_q      <= '0;
      pid_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
`ifdef CREG_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      guard_q   <= guard_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      wm_q      <= wm_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pv_q      <= pv_d;
      pid_q     <= pid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
`ifdef CREG_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign OUT_ce     = ce_q;
  assign OUT_we     = we_q;
  assign OUT_wm     = wm_q;
  assign OUT_addr   = addr_q;
  assign OUT_data   = data_q;
  assign OUT_rvalid = rvalid_q;
  assign OUT_rdata  = rdata_q;

endmodule

// File: tb/tb_creg_arbiter.sv
// Scoreboard bench for creg_arbiter: issue/read-return monitor plus per-scenario grant checks.
module tb_creg_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned RD_LAT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_v = '0, we_v = '0, lock_v = '0;
  logic [3:0]  wm_a   [2];
  logic [6:0]  addr_a [2];
  logic [31:0] data_a [2];
  logic [31:0] creg_data = '0;
  logic        io_busy = 1'b0;

  logic [1:0]  OUT_grant, OUT_rvalid;
  logic [31:0] OUT_rdata, OUT_data;
  logic        OUT_ce, OUT_we;
  logic [3:0]  OUT_wm;
  logic [6:0]  OUT_addr;

  always #5 clk = ~clk;

  creg_arbiter #(.NUM_REQ(NUM_REQ), .RD_LAT(RD_LAT), .IO_GUARD(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_req     (req_v),
    .IN_reqWe   (we_v),
    .IN_reqWm   ({wm_a[1], wm_a[0]}),
    .IN_reqAddr ({addr_a[1], addr_a[0]}),
    .IN_reqData ({data_a[1], data_a[0]}),
`ifdef CREG_ARB_LOCK_EN
    .IN_lock    (lock_v),
`endif
    .OUT_grant  (OUT_grant),
    .OUT_rvalid (OUT_rvalid),
    .OUT_rdata  (OUT_rdata),
    .OUT_ce     (OUT_ce),
    .OUT_we     (OUT_we),
    .OUT_wm     (OUT_wm),
    .OUT_addr   (OUT_addr),
    .OUT_data   (OUT_data),
    .IN_cregData(creg_data),
    .IN_ioBusy  (io_busy)
  );

  int n_run = 0, n_fail = 0, cyc = 0;

  typedef struct { int id; logic [31:0] data; int due; } rd_t;
  rd_t         rd_q[$];
  logic        iss_pend = 1'b0;
  logic [43:0] iss_exp;
  logic        mon_en = 1'b0, rst_prev = 1'b0;
  logic [6:0]  lat_addr = '0;
  logic [1:0]  exp_rv;
  int          mon_gid;

  // Register-port read model: data for an address depends only on that address
  function automatic logic [31:0] pat(input logic [6:0] a);
    return (a == 7'h01) ? 32'hDEADBEEF : {25'h1A5A5A5, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks the port access following each grant and every read return
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_prev) begin
        n_run++;
        if ({OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, OUT_rvalid, OUT_rdata} !==
            {1'b1, 1'b1, 4'h0, 7'h0, 32'h0, 2'b00, 32'h0}) begin
          n_fail++;
          $display("FAIL post_reset: ce=%b we=%b wm=%h addr=%h data=%h rvalid=%b rdata=%h, want idle/zero",
                   OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, OUT_rvalid, OUT_rdata);
        end
        rd_q.delete();
      end else begin
        n_run++;
        if (iss_pend) begin
          if ({OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data} !== {1'b0, iss_exp}) begin
            n_fail++;
            $display("FAIL issue @%0d: got ce=%b we=%b wm=%h addr=%h data=%h, want ce=0 {we,wm,addr,data}=%h",
                     cyc, OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, iss_exp);
          end
        end else if (OUT_ce !== 1'b1) begin
          n_fail++;
          $display("FAIL idle_ce @%0d: got ce=%b want 1", cyc, OUT_ce);
        end
        n_run++;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
          exp_rv = 2'b01 << rd_q[0].id;
          if ({OUT_rvalid, OUT_rdata} !== {exp_rv, rd_q[0].data}) begin
            n_fail++;
            $display("FAIL rdata @%0d: got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                     cyc, OUT_rvalid, OUT_rdata, exp_rv, rd_q[0].data);
          end
          void'(rd_q.pop_front());
        end else if (OUT_rvalid !== 2'b00) begin
          n_fail++;
          $display("FAIL spurious_rvalid @%0d: got %b want 00", cyc, OUT_rvalid);
        end
      end
      iss_pend = 1'b0;
      if (!rst && OUT_grant !== 2'b00) begin
        n_run++;
        if (!$onehot(OUT_grant) || ((OUT_grant & req_v) !== OUT_grant)) begin
          n_fail++;
          $display("FAIL grant_legal @%0d: got grant=%b req=%b", cyc, OUT_grant, req_v);
        end
        mon_gid  = OUT_grant[1] ? 1 : 0;
        iss_exp  = {~we_v[mon_gid], wm_a[mon_gid], addr_a[mon_gid], data_a[mon_gid]};
        iss_pend = 1'b1;
        if (!we_v[mon_gid]) rd_q.push_back('{mon_gid, pat(addr_a[mon_gid]), cyc + RD_LAT + 1});
      end
    end
    creg_data = pat(lat_addr);
    lat_addr  = OUT_addr;
    rst_prev  = rst;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic w, input logic [3:0] m,
                         input logic [6:0] a, input logic [31:0] d, input logic lk);
    req_v[id]  = 1'b1;
    we_v[id]   = w;
    wm_a[id]   = m;
    addr_a[id] = a;
    data_a[id] = d;
    lock_v[id] = lk;
  endtask

  task automatic idle(input int n);
    req_v  = '0;
    lock_v = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req_v = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_grant(input string name, input logic [1:0] want);
    @(negedge clk);
    n_run++;
    if (OUT_grant !== want) begin
      n_fail++;
      $display("FAIL %s @%0d: got grant=%b want %b", name, cyc, OUT_grant, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 4'h0, 7'h01, 32'h0, 1'b0);
    step(); step();
    @(negedge clk);
    n_run++;
    if ({OUT_grant, OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, OUT_rvalid, OUT_rdata} !==
        {2'b00, 1'b1, 1'b1, 4'h0, 7'h0, 32'h0, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_values: grant=%b ce=%b we=%b wm=%h addr=%h data=%h rvalid=%b rdata=%h",
               OUT_grant, OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, OUT_rvalid, OUT_rdata);
    end
    step();
    rst    = 1'b0;
    req_v  = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    step();
    set_req(0, 1'b0, 4'hF, 7'h01, 32'h0, 1'b0);
    chk_grant("single_read_grant", 2'b01);
    step();
    req_v = '0;
    @(negedge clk);
    n_run++;
    if ({OUT_ce, OUT_we, OUT_addr} !== {1'b0, 1'b1, 7'h01}) begin
      n_fail++;
      $display("FAIL single_read_issue: got ce=%b we=%b addr=%h want 0 1 01", OUT_ce, OUT_we, OUT_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if ({OUT_rvalid, OUT_rdata} !== {2'b01, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_read_return: got rvalid=%b rdata=%h want 01 deadbeef", OUT_rvalid, OUT_rdata);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b0, 4'h0, 7'h02, 32'h0, 1'b0);
    set_req(1, 1'b0, 4'h0, 7'h03, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_grant("alternate", (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        n_run++;
        if (OUT_ce !== 1'b0) begin
          n_fail++;
          $display("FAIL continuous_ce @%0d: got ce=%b want 0", cyc, OUT_ce);
        end
      end
      step();
    end
    idle(5);
  endtask

  task automatic test_io_guard();
    do_reset();
    set_req(0, 1'b1, 4'b1000, 7'h04, 32'h80000000, 1'b0);
    chk_grant("io_write_grant", 2'b01);
    step();
    req_v[0] = 1'b0;
    set_req(1, 1'b1, 4'h3, 7'h05, 32'h0000_1234, 1'b0);
    @(negedge clk);
    n_run++;
    if ({OUT_we, OUT_wm} !== {1'b0, 4'b1000}) begin
      n_fail++;
      $display("FAIL io_write_issue: got we=%b wm=%b want 0 1000", OUT_we, OUT_wm);
    end
    n_run++;
    if (OUT_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL guard_hold_1: got grant=%b want 00", OUT_grant);
    end
    step();
    chk_grant("guard_hold_2", 2'b00);
    step();
    chk_grant("guard_hold_3", 2'b00);
    step();
    chk_grant("guard_release", 2'b10);
    step();
    idle(4);
    set_req(0, 1'b1, 4'hF, 7'h04, 32'h0000_00AA, 1'b0);
    chk_grant("io_write_grant_b", 2'b01);
    step();
    req_v[0] = 1'b0;
    set_req(1, 1'b0, 4'h0, 7'h07, 32'h0, 1'b0);
    chk_grant("gpio_in_not_io", 2'b10);
    step();
    set_req(1, 1'b0, 4'h0, 7'h06, 32'h0, 1'b0);
    chk_grant("gpio_cfg_not_io", 2'b10);
    step();
    set_req(1, 1'b0, 4'h0, 7'h24, 32'h0, 1'b0);
    chk_grant("perf_not_io", 2'b10);
    step();
    set_req(1, 1'b0, 4'h0, 7'h05, 32'h0, 1'b0);
    chk_grant("io_read_after_guard", 2'b10);
    step();
    req_v[1] = 1'b0;
    set_req(0, 1'b1, 4'h1, 7'h04, 32'h0000_0001, 1'b0);
    chk_grant("io_read_loads_guard", 2'b00);
    step();
    idle(6);
  endtask

  task automatic test_io_busy();
    do_reset();
    io_busy = 1'b1;
    set_req(0, 1'b1, 4'hF, 7'h05, 32'h0000_0055, 1'b0);
    set_req(1, 1'b0, 4'h0, 7'h20, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk_grant("busy_bypass", 2'b10);
      step();
    end
    io_busy = 1'b0;
    chk_grant("busy_release", 2'b01);
    step();
    idle(6);
  endtask

  task automatic test_reset_mid();
    step();
    set_req(0, 1'b0, 4'h0, 7'h09, 32'h0, 1'b0);
    chk_grant("mid_read_grant", 2'b01);
    step();
    req_v = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if ({OUT_grant, OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, OUT_rvalid, OUT_rdata} !==
        {2'b00, 1'b1, 1'b1, 4'h0, 7'h0, 32'h0, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: grant=%b ce=%b we=%b wm=%h addr=%h data=%h rvalid=%b rdata=%h",
               OUT_grant, OUT_ce, OUT_we, OUT_wm, OUT_addr, OUT_data, OUT_rvalid, OUT_rdata);
    end
    step();
    set_req(0, 1'b1, 4'hF, 7'h04, 32'h0000_0077, 1'b0);
    chk_grant("pre_reset_io", 2'b01);
    step();
    req_v = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(1, 1'b1, 4'hF, 7'h05, 32'h0000_0088, 1'b0);
    chk_grant("guard_cleared", 2'b10);
    step();
    idle(6);
  endtask

`ifdef CREG_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(1, 1'b0, 4'h0, 7'h02, 32'h0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      set_req(0, 1'b1, 4'hF, (w == 1) ? 7'h05 : 7'h04, 32'h0000_0100 + w, (w < 2) ? 1'b1 : 1'b0);
      if (w > 0) begin
        for (int k = 0; k < 3; k++) begin
          chk_grant("lock_excludes", 2'b00);
          step();
        end
      end
      chk_grant("lock_owner", 2'b01);
      step();
    end
    req_v[0] = 1'b0;
    chk_grant("lock_released", 2'b10);
    step();
    idle(6);
  endtask
`endif

  initial begin
    for (int i = 0; i < 2; i++) begin
      wm_a[i] = '0; addr_a[i] = '0; data_a[i] = '0;
    end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_io_guard();
    test_io_busy();
    test_reset_mid();
`ifdef CREG_ARB_LOCK_EN
    test_lock();
`endif
    n_run++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL reads_outstanding: got %0d pending want 0", rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
